// File: rtl/iobus_timer.sv
// Memory-mapped interval timer on the MCU IOBUS: CTRL/COUNT/COMPARE/STATUS registers,
// prescaled tick, one-shot or auto-reload compare, level interrupt on MATCH & IE.
module iobus_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'h1100_0200,
  parameter int          PRESCALE_W = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] RD_DATA,
  output logic        SEL,
  output logic        INTR
);

  localparam logic [PRESCALE_W-1:0] PCNT_ONE = 1;

  logic                  en_q, en_d;
  logic                  ie_q, ie_d;
  logic                  auto_q, auto_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           compare_q, compare_d;
  logic                  match_q, match_d;
  logic                  ovr_q, ovr_d;

  logic       wr_en, wr_ctrl, wr_count, wr_cmp, wr_status;
  logic       tick, hit;
  logic [1:0] off;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^IOBUS_ADDR[1:0];

  assign SEL       = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
  assign off       = IOBUS_ADDR[3:2];
  assign wr_en     = IOBUS_WR & SEL;
  assign wr_ctrl   = wr_en & (off == 2'd0);
  assign wr_count  = wr_en & (off == 2'd1);
  assign wr_cmp    = wr_en & (off == 2'd2);
  assign wr_status = wr_en & (off == 2'd3);

  assign tick = en_q & (pcnt_q == presc_q);
  // A COUNT write in the same cycle overrides the compare, so it also suppresses the match.
  assign hit  = tick & ~wr_count & (count_q == compare_q);

  assign INTR = match_q & ie_q;

  always_comb begin
    en_d      = en_q;
    ie_d      = ie_q;
    auto_d    = auto_q;
    presc_d   = presc_q;
    pcnt_d    = pcnt_q;
    count_d   = count_q;
    compare_d = compare_q;
    match_d   = match_q & ~(wr_status & IOBUS_OUT[0]);
    ovr_d     = ovr_q & ~(wr_status & IOBUS_OUT[1]);

    if (wr_ctrl) begin
      en_d    = IOBUS_OUT[0];
      ie_d    = IOBUS_OUT[1];
      auto_d  = IOBUS_OUT[2];
      presc_d = IOBUS_OUT[8 +: PRESCALE_W];
    end else if (hit && !auto_q) begin
      en_d = 1'b0;
    end

    if (wr_ctrl || tick) pcnt_d = '0;
    else if (en_q)       pcnt_d = pcnt_q + PCNT_ONE;

    if (wr_count)      count_d = IOBUS_OUT;
    else if (hit)      count_d = auto_q ? 32'd0 : count_q;
    else if (tick)     count_d = count_q + 32'd1;

    if (wr_cmp) compare_d = IOBUS_OUT;

    // Hardware set beats W1C; OVERRUN looks at MATCH before any clear.
    if (hit) begin
      match_d = 1'b1;
      if (match_q) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      en_q      <= 1'b0;
      ie_q      <= 1'b0;
      auto_q    <= 1'b0;
      presc_q   <= '0;
      pcnt_q    <= '0;
      count_q   <= '0;
      compare_q <= '0;
      match_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      en_q      <= en_d;
      ie_q      <= ie_d;
      auto_q    <= auto_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      match_q   <= match_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    RD_DATA = 32'd0;
    if (SEL) begin
      case (off)
        2'd0: begin
          RD_DATA[0]                = en_q;
          RD_DATA[1]                = ie_q;
          RD_DATA[2]                = auto_q;
          RD_DATA[8 +: PRESCALE_W]  = presc_q;
        end
        2'd1:    RD_DATA = count_q;
        2'd2:    RD_DATA = compare_q;
        default: RD_DATA = {30'd0, ovr_q, match_q};
      endcase
    end
  end

endmodule

// File: tb/tb_iobus_timer.sv
// Directed bench for iobus_timer: readback, one-shot, prescaled periodic, collisions,
// address decode and 32-bit wrap, each with hand-computed expectations.
module tb_iobus_timer;

  localparam logic [31:0] A_CTRL   = 32'h1100_0200;
  localparam logic [31:0] A_COUNT  = 32'h1100_0204;
  localparam logic [31:0] A_CMP    = 32'h1100_0208;
  localparam logic [31:0] A_STATUS = 32'h1100_020C;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] IOBUS_ADDR = 32'd0;
  logic [31:0] IOBUS_OUT = 32'd0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] RD_DATA;
  logic        SEL;
  logic        INTR;

  int checks = 0;
  int errors = 0;

  iobus_timer dut (
    .CLK(CLK), .RESET(RESET), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
    .IOBUS_WR(IOBUS_WR), .RD_DATA(RD_DATA), .SEL(SEL), .INTR(INTR)
  );

  always #5 CLK = ~CLK;

  // All tasks leave time at 1 unit after a rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    IOBUS_ADDR = a; IOBUS_OUT = d; IOBUS_WR = 1'b1;
    @(posedge CLK);
    #1;
    IOBUS_WR = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    IOBUS_ADDR = a;
    #1;
    d = RD_DATA;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    #1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    wr(A_CTRL, 32'h0000_0003);
    cyc(1);
    checks++; if (INTR !== 1'b1) begin errors++; $display("FAIL pre_reset_intr got %b exp 1", INTR); end
    RESET = 1'b1;
    #1;
    checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL async_reset_intr got %b exp 0", INTR); end
    @(posedge CLK); #1;
    RESET = 1'b0;
    rd(A_CTRL, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_ctrl got %h exp 00000000", v); end
    rd(A_COUNT, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_count got %h exp 00000000", v); end
    rd(A_CMP, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_compare got %h exp 00000000", v); end
    rd(A_STATUS, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_status got %h exp 00000000", v); end
    wr(A_CTRL, 32'hFFFF_FFFF);
    rd(A_CTRL, v);
    checks++; if (v !== 32'h0000_FF07) begin errors++; $display("FAIL ctrl_readback got %h exp 0000ff07", v); end
    do_reset();
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    wr(A_CMP, 32'd3);
    wr(A_COUNT, 32'd0);
    wr(A_CTRL, 32'h0000_0003);
    cyc(3);
    checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL oneshot_early_intr got %b exp 0", INTR); end
    rd(A_COUNT, v);
    checks++; if (v !== 32'd3) begin errors++; $display("FAIL oneshot_count3 got %h exp 00000003", v); end
    cyc(1);
    checks++; if (INTR !== 1'b1) begin errors++; $display("FAIL oneshot_intr got %b exp 1", INTR); end
    rd(A_STATUS, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL oneshot_status got %h exp 00000001", v); end
    rd(A_CTRL, v);
    checks++; if (v !== 32'd2) begin errors++; $display("FAIL oneshot_en_clear got %h exp 00000002", v); end
    cyc(2);
    rd(A_COUNT, v);
    checks++; if (v !== 32'd3) begin errors++; $display("FAIL oneshot_count_hold got %h exp 00000003", v); end
    wr(A_STATUS, 32'd1);
    checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL oneshot_intr_clear got %b exp 0", INTR); end
    do_reset();
  endtask

  task automatic test_periodic();
    logic [31:0] v;
    wr(A_CMP, 32'd1);
    wr(A_CTRL, 32'h0000_0205);
    cyc(3);
    rd(A_COUNT, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL periodic_count1 got %h exp 00000001", v); end
    rd(A_STATUS, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL periodic_status0 got %h exp 00000000", v); end
    cyc(2);
    rd(A_STATUS, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL periodic_early got %h exp 00000000", v); end
    cyc(1);
    rd(A_STATUS, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL periodic_match1 got %h exp 00000001", v); end
    rd(A_COUNT, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL periodic_reload got %h exp 00000000", v); end
    cyc(6);
    rd(A_STATUS, v);
    checks++; if (v !== 32'd3) begin errors++; $display("FAIL periodic_overrun got %h exp 00000003", v); end
    // Now at edge 12; next matches land on edges 18 and 24.
    wr(A_STATUS, 32'd3);
    rd(A_STATUS, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL w1c_clear got %h exp 00000000", v); end
    cyc(4);
    wr(A_STATUS, 32'd3);
    rd(A_STATUS, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL w1c_vs_set got %h exp 00000001", v); end
    cyc(5);
    wr(A_STATUS, 32'd1);
    rd(A_STATUS, v);
    checks++; if (v !== 32'd3) begin errors++; $display("FAIL w1c_preclear_ovr got %h exp 00000003", v); end
    do_reset();
  endtask

  task automatic test_count_collision();
    logic [31:0] v;
    wr(A_CMP, 32'd100);
    wr(A_CTRL, 32'h0000_0001);
    wr(A_COUNT, 32'h10);
    rd(A_COUNT, v);
    checks++; if (v !== 32'h10) begin errors++; $display("FAIL count_write_wins got %h exp 00000010", v); end
    cyc(1);
    rd(A_COUNT, v);
    checks++; if (v !== 32'h11) begin errors++; $display("FAIL count_after_write got %h exp 00000011", v); end
    do_reset();
  endtask

  task automatic test_decode();
    logic [31:0] v;
    wr(A_COUNT, 32'h55);
    IOBUS_ADDR = 32'h1100_0214; IOBUS_OUT = 32'hFFFF_FFFF; IOBUS_WR = 1'b1;
    #1;
    checks++; if (SEL !== 1'b0) begin errors++; $display("FAIL decode_sel_hi got %b exp 0", SEL); end
    checks++; if (RD_DATA !== 32'd0) begin errors++; $display("FAIL decode_rd_hi got %h exp 00000000", RD_DATA); end
    @(posedge CLK); #1;
    IOBUS_ADDR = 32'h1100_0104;
    #1;
    checks++; if (SEL !== 1'b0) begin errors++; $display("FAIL decode_sel_lo got %b exp 0", SEL); end
    checks++; if (RD_DATA !== 32'd0) begin errors++; $display("FAIL decode_rd_lo got %h exp 00000000", RD_DATA); end
    @(posedge CLK); #1;
    IOBUS_WR = 1'b0;
    rd(A_COUNT, v);
    checks++; if (v !== 32'h55) begin errors++; $display("FAIL decode_count got %h exp 00000055", v); end
    rd(A_CTRL, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL decode_ctrl got %h exp 00000000", v); end
    IOBUS_ADDR = A_COUNT; IOBUS_OUT = 32'h99;
    #1;
    checks++; if (SEL !== 1'b1) begin errors++; $display("FAIL decode_sel_hit got %b exp 1", SEL); end
    cyc(1);
    rd(A_COUNT, v);
    checks++; if (v !== 32'h55) begin errors++; $display("FAIL no_strobe_count got %h exp 00000055", v); end
    do_reset();
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    wr(A_CMP, 32'd5);
    wr(A_COUNT, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'h0000_0001);
    cyc(1);
    rd(A_COUNT, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL wrap_count got %h exp 00000000", v); end
    rd(A_STATUS, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL wrap_no_flag got %h exp 00000000", v); end
    cyc(5);
    rd(A_COUNT, v);
    checks++; if (v !== 32'd5) begin errors++; $display("FAIL wrap_count5 got %h exp 00000005", v); end
    rd(A_STATUS, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL wrap_pre_match got %h exp 00000000", v); end
    cyc(1);
    rd(A_STATUS, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL wrap_match got %h exp 00000001", v); end
    rd(A_CTRL, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL wrap_oneshot_en got %h exp 00000000", v); end
    do_reset();
  endtask

  initial begin
    do_reset();
    test_reset();
    test_oneshot();
    test_periodic();
    test_count_collision();
    test_decode();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iobus_timer.md
Name: iobus_timer

Overview:
- Memory-mapped interval timer. It is the responder on the MCU's IOBUS: it decodes IOBUS_ADDR, captures writes on the IOBUS_WR strobe, and returns read data on a combinational path.
- Generates a level interrupt for the MCU INTR input on compare match.
- Sits at the top level beside the MCU. Its read-data output is OR-combined with other peripherals into IOBUS_IN.

Parameters:
- BASE_ADDR, 32'h1100_0200, base of the 16-byte register window; bits [3:0] must be zero.
- PRESCALE_W, 8, width of the CTRL prescale field and the prescaler counter.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-high reset.
- IOBUS_ADDR  in  32  byte address from the MCU.
- IOBUS_OUT  in  32  write data from the MCU (rs2).
- IOBUS_WR  in  1  single-cycle write strobe from the MCU.
- RD_DATA  out  32  read data; combinational; 0 when not selected.
- SEL  out  1  address hit: IOBUS_ADDR[31:4] == BASE_ADDR[31:4].
- INTR  out  1  interrupt request level to the MCU.

Behaviour:
- Register map (offset = IOBUS_ADDR[3:2]; IOBUS_ADDR[1:0] ignored; word access only):
  - 0x0 CTRL: [0] EN, [1] IE, [2] AUTO, [8+:PRESCALE_W] PRESCALE; all other bits read 0.
  - 0x4 COUNT: 32-bit current count. Read/write; a write loads the value.
  - 0x8 COMPARE: 32-bit terminal value. Read/write.
  - 0xC STATUS: [0] MATCH, [1] OVERRUN. Write-1-to-clear; writing 0 has no effect; other bits read 0.
- Write path:
  - A write occurs on the posedge where IOBUS_WR=1 and SEL=1.
  - IOBUS_WR with SEL=0 is ignored.
  - Writes take effect in the next cycle.
- Read path:
  - RD_DATA is a pure function of IOBUS_ADDR and current register state.
  - It reflects a write starting the cycle after that write.
- Reset (asynchronous): all registers 0; prescaler counter 0. As a result RD_DATA=0, SEL follows the address, INTR=0.
- Prescaler:
  - 8-bit counter pcnt, running only while EN=1.
  - tick = EN & (pcnt == PRESCALE). On tick, pcnt goes to 0; otherwise pcnt+1.
  - PRESCALE=0 gives a tick every cycle; PRESCALE=N gives a tick every N+1 cycles.
  - Any CTRL write clears pcnt.
  - EN=0 holds pcnt and COUNT.
- Counter, on tick:
  - If COUNT == COMPARE:
    - MATCH is set.
    - OVERRUN is set if MATCH was already 1.
    - If AUTO=1, COUNT goes to 0 and the timer keeps running.
    - If AUTO=0, EN is cleared (one-shot) and COUNT holds at COMPARE.
  - Otherwise COUNT+1, wrapping 32'hFFFF_FFFF to 0. No flag is raised on wrap.
  - COMPARE=0 with AUTO=1 matches on every tick.
- Interrupt: INTR = MATCH & IE, decoded from registers only. It asserts the cycle after the match tick edge and stays high until MATCH is cleared or IE=0.
- Simultaneous events:
  - COUNT write and tick in the same cycle: the write wins; no compare/increment that cycle.
  - STATUS W1C and a hardware MATCH set in the same cycle: the set wins, and OVERRUN follows its normal rule using the pre-clear MATCH.
  - CTRL write and a one-shot auto-clear of EN in the same cycle: the written CTRL value wins.
  - COMPARE write and tick in the same cycle: the compare uses the old COMPARE.
- Reset mid-count: asserting RESET asynchronously zeroes all state and deasserts INTR immediately. No pending state survives.

Test Plan:
- Reset/readback:
  - Assert RESET mid-run; INTR falls without waiting for a clock.
  - After release, reads of 0x1100_0200/04/08/0C return 0.
  - Write CTRL=32'hFFFF_FFFF, read back 32'h0000_FF07.
- One-shot:
  - COMPARE=3, COUNT=0, CTRL=EN|IE (PRESCALE=0).
  - MATCH and INTR rise 4 cycles after the CTRL write lands; EN reads 0; COUNT holds 3.
  - Write STATUS=1; INTR drops the next cycle.
- Periodic with prescale:
  - CTRL=EN|AUTO|(2<<8), COMPARE=1.
  - Ticks every 3 cycles; MATCH sets every 6 cycles.
  - A second match without a clear sets OVERRUN; STATUS reads 3.
- Collisions:
  - Issue a STATUS W1C on the same edge as a match tick; MATCH remains 1.
  - Issue a COUNT=32'h10 write on a tick edge; COUNT reads 32'h10, not incremented.
- Decode:
  - Write to 0x1100_0210 and to 0x1100_0100 with IOBUS_WR=1; no register changes; SEL=0; RD_DATA=0.
  - IOBUS_WR=0 at 0x1100_0204 leaves COUNT unchanged.
- Wrap:
  - COUNT=32'hFFFF_FFFF, COMPARE=5, EN, PRESCALE=0.
  - COUNT reads 0 the next cycle, then matches 6 cycles after wrap; no flag is raised at wrap.
